// File: rtl/blink_decoder_if.sv
// Signal bundle between a blink-style heartbeat source and its decoder.
// The source side drives led_in; the decoder side returns status.
interface blink_decoder_if #(
   parameter int CBITS = 12
);
   logic             led_in;
   logic             edge_pulse;
   logic             phase;
   logic             locked;
   logic             err;
   logic [7:0]       err_cnt;
   logic [CBITS+1:0] last_interval;

   modport master (
      output led_in,
      input  edge_pulse, phase, locked, err, err_cnt, last_interval
   );

   modport slave (
      input  led_in,
      output edge_pulse, phase, locked, err, err_cnt, last_interval
   );
endinterface

// File: rtl/blink_decoder.sv
// Heartbeat monitor: times led_in toggles against a 2**CBITS half-period,
// locks after LOCK_N good intervals and flags mismatches / stuck LED.
module blink_decoder #(
   parameter int CBITS  = 12,
   parameter int TOL    = 0,
   parameter int LOCK_N = 4
) (
   input  logic             clk,
   input  logic             rst,
   blink_decoder_if.slave   bus
);
   localparam int W   = CBITS + 2;
   localparam int EXP = 1 << CBITS;
   localparam logic [W-1:0] LO = W'(EXP - TOL);
   localparam logic [W-1:0] HI = W'(EXP + TOL);

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

   state_t         state, state_d;
   logic           led_q;
   logic [W-1:0]   cnt;
   logic [3:0]     match_cnt, match_cnt_d;
   logic           err_d;
   logic           edge_det;
   logic           in_range;
   logic           edge_pulse_q;
   logic           locked_q;
   logic           err_q;
   logic [7:0]     err_cnt_q;
   logic [W-1:0]   last_interval_q;

   assign edge_det = (bus.led_in != led_q);
   assign in_range = (cnt >= LO) && (cnt <= HI);

   always_comb begin
      state_d     = state;
      match_cnt_d = match_cnt;
      err_d       = 1'b0;
      case (state)
         IDLE: begin
            if (edge_det) state_d = HUNT;
         end
         HUNT: begin
            if (edge_det) begin
               if (in_range) begin
                  match_cnt_d = match_cnt + 4'd1;
                  if (match_cnt_d == 4'(LOCK_N)) state_d = LOCKED;
               end else begin
                  match_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            // stuck-LED timeout can only fire on a non-edge cycle, so an
            // edge landing exactly on HI is judged by the match rule alone
            if ((edge_det && !in_range) || (!edge_det && cnt == HI)) begin
               err_d       = 1'b1;
               match_cnt_d = '0;
               state_d     = HUNT;
            end
         end
         default: begin
            state_d     = IDLE;
            match_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         led_q           <= 1'b0;
         cnt             <= '0;
         match_cnt       <= '0;
         edge_pulse_q    <= 1'b0;
         locked_q        <= 1'b0;
         err_q           <= 1'b0;
         err_cnt_q       <= '0;
         last_interval_q <= '0;
      end else begin
         state        <= state_d;
         match_cnt    <= match_cnt_d;
         led_q        <= bus.led_in;
         edge_pulse_q <= edge_det;
         locked_q     <= (state_d == LOCKED);
         err_q        <= err_d;

         if (edge_det)
            cnt <= W'(1);
         else if (cnt != '1)
            cnt <= cnt + W'(1);

         // the first edge after reset only starts timing
         if (edge_det && state != IDLE)
            last_interval_q <= cnt;

         if (err_d && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign bus.edge_pulse    = edge_pulse_q;
   assign bus.phase         = led_q;
   assign bus.locked        = locked_q;
   assign bus.err           = err_q;
   assign bus.err_cnt       = err_cnt_q;
   assign bus.last_interval = last_interval_q;
endmodule
